// File: rtl/mac_operand_feeder.sv
// Operand feeder for a single MAC: buffers one activation and one weight vector,
// streams them pairwise into the MAC and reports the dot product as a baseline delta.
module mac_operand_feeder #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 16,
  parameter int MAC_LAT = 3,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             wr_en,
  input  logic             wr_sel,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW:0]      len,
  input  logic             start,
  input  logic [WIDTH-1:0] mac_out,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             err
);

  localparam int CW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] act_mem [DEPTH];
  logic [WIDTH-1:0] wgt_mem [DEPTH];
  logic [WIDTH-1:0] baseline;
  logic [AW:0]      len_q;
  logic [AW:0]      idx;
  logic [CW-1:0]    drain_cnt;
  logic             len_ok;
  logic             start_ok;
  logic             wr_ok;

  assign len_ok   = (len != '0) && (len <= (AW+1)'(DEPTH));
  assign start_ok = (state == IDLE) && start && len_ok;
  assign wr_ok    = wr_en && !busy && !start_ok && ({1'b0, wr_addr} < (AW+1)'(DEPTH));

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = STREAM;
      STREAM:  if (idx == len_q) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // DONE is the only non-busy cycle in which start is still refused,
  // which keeps mac_out settled before the next baseline capture.
  always_comb begin
    busy         = 1'b0;
    result_valid = 1'b0;
    case (state)
      STREAM, DRAIN: busy = 1'b1;
      DONE:          result_valid = 1'b1;
      default:       ;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < DEPTH; i++) begin
        act_mem[i] <= '0;
        wgt_mem[i] <= '0;
      end
    end else if (wr_ok) begin
      if (wr_sel) wgt_mem[wr_addr] <= wr_data;
      else        act_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      a_out     <= '0;
      b_out     <= '0;
      result    <= '0;
      err       <= 1'b0;
      baseline  <= '0;
      len_q     <= '0;
      idx       <= '0;
      drain_cnt <= '0;
    end else begin
      err <= (state == IDLE) && start && !len_ok;
      case (state)
        IDLE: begin
          if (start_ok) begin
            baseline <= mac_out;
            len_q    <= len;
            a_out    <= act_mem[0];
            b_out    <= wgt_mem[0];
            idx      <= (AW+1)'(1);
          end
        end
        STREAM: begin
          if (idx == len_q) begin
            a_out     <= '0;
            b_out     <= '0;
            drain_cnt <= CW'(MAC_LAT - 1);
          end else begin
            a_out <= act_mem[idx[AW-1:0]];
            b_out <= wgt_mem[idx[AW-1:0]];
            idx   <= idx + (AW+1)'(1);
          end
        end
        DRAIN: begin
          // Modular subtraction matches the MAC's own truncated accumulation.
          if (drain_cnt == '0) result <= mac_out - baseline;
          else                 drain_cnt <= drain_cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed bench for mac_operand_feeder driving a small 3-stage MAC model
// (operand register, product register, accumulator).
module tb_mac_operand_feeder;

  localparam int WIDTH   = 16;
  localparam int DEPTH   = 16;
  localparam int MAC_LAT = 3;
  localparam int AW      = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rstb;
  logic             wr_en;
  logic             wr_sel;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [AW:0]      len;
  logic             start;
  logic [WIDTH-1:0] mac_out;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic             busy;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             err;

  int checks   = 0;
  int failures = 0;

  mac_operand_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .rstb(rstb), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .len(len), .start(start), .mac_out(mac_out),
    .a_out(a_out), .b_out(b_out), .busy(busy), .result(result),
    .result_valid(result_valid), .err(err)
  );

  always #5 clk = ~clk;

  // MAC model: product enters the accumulator two edges after capture,
  // so it is visible before the feeder samples mac_out MAC_LAT edges later.
  logic [WIDTH-1:0] mac_a, mac_b, mac_p, mac_acc;
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      mac_a <= '0; mac_b <= '0; mac_p <= '0; mac_acc <= '0;
    end else begin
      mac_a   <= a_out;
      mac_b   <= b_out;
      mac_p   <= WIDTH'(mac_a * mac_b);
      mac_acc <= mac_acc + mac_p;
    end
  end
  assign mac_out = mac_acc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic sel, input int addr, input logic [WIDTH-1:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = AW'(addr);
    wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  // Starts a job and waits (bounded) for result_valid; cyc is the cycle index
  // of the pulse counted from the start-acceptance cycle.
  task automatic run_job(input int n, output logic [WIDTH-1:0] res, output int cyc,
                         output logic busy_at_valid);
    len   = (AW+1)'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 1;
    while (!result_valid && cyc < 200) begin
      tick();
      cyc++;
    end
    res           = result;
    busy_at_valid = busy;
    tick();
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    #3;
    checks++;
    if ({a_out, b_out, result} !== '0 || {busy, result_valid, err} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got a=%h b=%h res=%h busy=%b rv=%b err=%b required all 0",
               a_out, b_out, result, busy, result_valid, err);
    end
    #14;
    rstb = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] exp_a [4] = '{16'd1, 16'd2, 16'd3, 16'd4};
    logic [WIDTH-1:0] exp_b [4] = '{16'd5, 16'd6, 16'd7, 16'd8};
    int cyc;
    logic bsy;
    for (int i = 0; i < 4; i++) begin
      write_word(1'b0, i, exp_a[i]);
      write_word(1'b1, i, exp_b[i]);
    end
    len   = 5'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL basic_busy: got %b required 1", busy);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (a_out !== exp_a[k] || b_out !== exp_b[k]) begin
        failures++;
        $display("[TB] FAIL basic_pair%0d: got a=%h b=%h required a=%h b=%h",
                 k, a_out, b_out, exp_a[k], exp_b[k]);
      end
      tick();
      cyc++;
    end
    checks++;
    if (a_out !== '0 || b_out !== '0) begin
      failures++;
      $display("[TB] FAIL basic_zero_after: got a=%h b=%h required 0", a_out, b_out);
    end
    while (!result_valid && cyc < 200) begin
      tick();
      cyc++;
    end
    bsy = busy;
    checks++;
    if (result !== 16'h0046 || cyc !== 8 || bsy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_result: got res=%h cyc=%0d busy=%b required res=0046 cyc=8 busy=0",
               result, cyc, bsy);
    end
    tick();
    checks++;
    if (result_valid !== 1'b0 || result !== 16'h0046) begin
      failures++;
      $display("[TB] FAIL basic_pulse_hold: got rv=%b res=%h required rv=0 res=0046",
               result_valid, result);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] res;
    int cyc;
    logic bsy;
    write_word(1'b0, 0, 16'd2);
    write_word(1'b0, 1, 16'd2);
    write_word(1'b1, 0, 16'd3);
    write_word(1'b1, 1, 16'd3);
    run_job(2, res, cyc, bsy);
    checks++;
    if (res !== 16'd12 || cyc !== 6) begin
      failures++;
      $display("[TB] FAIL b2b_result: got res=%h cyc=%0d required res=000c cyc=6", res, cyc);
    end
  endtask

  task automatic test_signed_wrap();
    logic [WIDTH-1:0] res;
    int cyc;
    logic bsy;
    write_word(1'b0, 0, 16'hFFFD);
    write_word(1'b1, 0, 16'd7);
    run_job(1, res, cyc, bsy);
    checks++;
    if (res !== 16'hFFEB || cyc !== 5) begin
      failures++;
      $display("[TB] FAIL signed_neg: got res=%h cyc=%0d required res=ffeb cyc=5", res, cyc);
    end
    write_word(1'b0, 0, 16'h7FFF);
    write_word(1'b1, 0, 16'd2);
    run_job(1, res, cyc, bsy);
    checks++;
    if (res !== 16'hFFFE) begin
      failures++;
      $display("[TB] FAIL signed_trunc: got res=%h required res=fffe", res);
    end
  endtask

  task automatic test_illegal_len();
    int bad_len [2] = '{0, 17};
    for (int t = 0; t < 2; t++) begin
      len   = (AW+1)'(bad_len[t]);
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || a_out !== '0 || b_out !== '0) begin
        failures++;
        $display("[TB] FAIL illegal_len%0d_err: got err=%b busy=%b a=%h b=%h required err=1 busy=0 a=0 b=0",
                 bad_len[t], err, busy, a_out, b_out);
      end
      tick();
      checks++;
      if (err !== 1'b0 || result_valid !== 1'b0 || busy !== 1'b0 || result !== 16'hFFFE) begin
        failures++;
        $display("[TB] FAIL illegal_len%0d_after: got err=%b rv=%b busy=%b res=%h required 0 0 0 fffe",
                 bad_len[t], err, result_valid, busy, result);
      end
    end
  endtask

  task automatic test_full_len_ignore();
    logic [WIDTH-1:0] res;
    int cyc;
    logic bsy;
    for (int i = 0; i < DEPTH; i++) begin
      write_word(1'b0, i, WIDTH'(i));
      write_word(1'b1, i, 16'd1);
    end
    len   = 5'd16;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 1;
    while (!result_valid && cyc < 200) begin
      if (cyc == 5) begin
        start = 1'b1;
        len   = 5'd2;
      end else begin
        start = 1'b0;
      end
      if (cyc >= 6 && cyc <= 10) begin
        wr_en   = 1'b1;
        wr_sel  = 1'b1;
        wr_addr = 4'd15;
        wr_data = 16'd100;
      end else begin
        wr_en = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    wr_en = 1'b0;
    checks++;
    if (result !== 16'd120 || cyc !== 20) begin
      failures++;
      $display("[TB] FAIL full_len_result: got res=%h cyc=%0d required res=0078 cyc=20", result, cyc);
    end
    tick();
    run_job(16, res, cyc, bsy);
    checks++;
    if (res !== 16'd120) begin
      failures++;
      $display("[TB] FAIL full_len_wgt15_kept: got res=%h required res=0078", res);
    end
  endtask

  task automatic test_reset_midjob();
    logic [WIDTH-1:0] res;
    int cyc;
    logic bsy;
    int rv_seen = 0;
    len   = 5'd8;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    rstb = 1'b0;
    #1;
    checks++;
    if ({a_out, b_out, result} !== '0 || {busy, result_valid, err} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL midjob_reset: got a=%h b=%h res=%h busy=%b rv=%b err=%b required all 0",
               a_out, b_out, result, busy, result_valid, err);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (result_valid) rv_seen++;
      if (i == 2) rstb = 1'b1;
    end
    checks++;
    if (rv_seen !== 0) begin
      failures++;
      $display("[TB] FAIL midjob_no_valid: got %0d pulses required 0", rv_seen);
    end
    write_word(1'b0, 0, 16'd4);
    write_word(1'b1, 0, 16'd4);
    run_job(1, res, cyc, bsy);
    checks++;
    if (res !== 16'd16 || cyc !== 5) begin
      failures++;
      $display("[TB] FAIL post_reset_job: got res=%h cyc=%0d required res=0010 cyc=5", res, cyc);
    end
  endtask

  initial begin
    wr_en   = 1'b0;
    wr_sel  = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    len     = '0;
    start   = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_signed_wrap();
    test_illegal_len();
    test_full_len_ignore();
    test_reset_midjob();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_operand_feeder.md
Name: mac_operand_feeder

Overview:
- Producer side of the MAC operand interface. Holds one activation vector and one weight vector in local register files, streams them pairwise into a MAC on start, then returns the dot product.
- Result is mac_out at completion minus a baseline captured at start, so the MAC accumulator never needs clearing between jobs.
- Sits between the PE controller/loader and one mac instance. a_out drives MAC A, b_out drives MAC B, and MAC out drives mac_out.

Parameters:
- WIDTH, 16, operand/result bit width; must match the attached MAC.
- DEPTH, 16, max vector length, i.e. entries per register file. AW = $clog2(DEPTH) is derived.
- MAC_LAT, 3, cycles from operand capture edge at the MAC to its out register including that product.

Ports:
- clk  in  1  clock, rising edge.
- rstb  in  1  reset, asynchronous, active-low.
- wr_en  in  1  write strobe into operand buffers.
- wr_sel  in  1  0 = activation file, 1 = weight file.
- wr_addr  in  AW  write index.
- wr_data  in  WIDTH  signed write data.
- len  in  AW+1  number of pairs for this job; legal range 1..DEPTH.
- start  in  1  job request, sampled when busy=0.
- mac_out  in  WIDTH  signed MAC accumulator output.
- a_out  out  WIDTH  registered activation operand to the MAC.
- b_out  out  WIDTH  registered weight operand to the MAC.
- busy  out  1  job in progress.
- result  out  WIDTH  signed dot product; holds until the next job completes.
- result_valid  out  1  one-cycle pulse when result updates.
- err  out  1  one-cycle pulse on an illegal start.

Behaviour:
- Reset (async, rstb=0):
  - a_out, b_out, result, busy, result_valid and err are 0.
  - Both register files and the baseline register are cleared to 0.
  - FSM goes to IDLE and all counters to 0.
  - Reset mid-job aborts the job with no result_valid. a_out/b_out go to 0 immediately.
- FSM states: IDLE, STREAM, DRAIN, DONE.
- IDLE:
  - a_out = b_out = 0, so MAC products are 0 and the accumulator holds.
  - If start=1 and 1<=len<=DEPTH, the start is accepted at edge E0:
    - baseline <= mac_out.
    - Latch len.
    - a_out <= act[0], b_out <= wgt[0], idx <= 1.
    - Go to STREAM; busy=1 from E0.
  - If start=1 and (len==0 or len>DEPTH):
    - err pulses the next cycle.
    - State, busy and outputs are unchanged.
- STREAM:
  - At edge Ek, for 1<=k<len: a_out <= act[k], b_out <= wgt[k].
  - At edge E(len): a_out <= 0, b_out <= 0, go to DRAIN, and load the drain counter with MAC_LAT-1.
  - Pair k is therefore presented during the cycle after Ek.
- DRAIN:
  - Counter decrements each edge; operands stay 0.
  - At edge E(len+MAC_LAT): result <= mac_out - baseline (mod 2^WIDTH), go to DONE.
- DONE:
  - result_valid=1 and busy=0 for exactly this cycle; then go to IDLE.
  - start is not accepted in DONE; the first acceptable start is the cycle after result_valid.
  - This guarantees mac_out is stable for the next baseline capture.
- Arithmetic:
  - The subtraction is WIDTH-bit two's complement, wrap-around, no saturation.
  - The result equals the MAC's own WIDTH-bit truncated sum of products.
- Writes:
  - Accepted only when busy=0 and no start is accepted that cycle.
  - Writes while busy, or in the same cycle as an accepted start, are dropped silently.
  - wr_addr >= DEPTH is dropped.
- start while busy=1 is ignored; no err.
- Latency: result_valid is asserted len+MAC_LAT+1 cycles after the start-acceptance cycle.

Test Plan:
- Write act={1,2,3,4}, wgt={5,6,7,8}, start with len=4 after MAC reset -> a_out/b_out pairs on cycles E0..E3, zeros after; result=70 (0x0046) with result_valid 8 cycles after start; busy low in the pulse cycle.
- Immediately after the previous job (mac_out=70), write act={2,2}, wgt={3,3}, len=2 -> result=12, not 82; baseline captured as 70.
- act[0]=-3, wgt[0]=7, len=1 -> result=0xFFEB (-21). Repeat with act[0]=0x7FFF, wgt[0]=2 -> result=0xFFFE (matches the MAC's truncated product).
- start with len=0, then with len=17 -> err pulse each time; busy stays 0, a_out/b_out stay 0, no result_valid, result unchanged.
- len=16 with act[i]=i, wgt[i]=1 -> result=120. Mid-job pulses are all ignored: start at cycle 5, and writes at cycles 6–10 that change wgt[15] -> still 120, wgt[15] still 1.
- Assert rstb=0 at cycle 3 of a len=8 job -> all outputs 0 asynchronously, no result_valid. After release, a new len=1 job (act=4, wgt=4, MAC also reset) returns result=16.
